// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: state encoding, datapath
// widths, default timeout and the ALU opcodes used by execute.
package mem_access_unit_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_timeout.sv
// Clearable saturating cycle counter; flags when the count reaches LIMIT-1.
module lsu_timeout_cnt #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles, restart on clear, hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: turns EX loads/stores into req/gnt/rvalid transactions,
// stalls the pipeline while busy and presents a registered writeback.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  load_en,
  input  logic                  store_en,
  input  logic                  write_reg,
  input  logic [XLEN-1:0]       ex_res,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic                  misalign_err,
  output logic                  bus_err
);

  logic [1:0]            state_q, state_d;
  logic [XLEN-1:0]       addr_q, wdata_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  is_load_q;

  logic idle, busy, accept, aligned, start, completion, expired, timeout, passthru;

  assign idle       = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_REQ) || (state_q == ST_RESP);
  assign accept     = idle && ex_valid && (load_en || store_en);
  assign aligned    = is_word_aligned(ex_res);
  assign start      = accept && aligned;
  // rvalid only counts in RESP, so a same-cycle gnt+rvalid in REQ is a grant.
  assign completion = (state_q == ST_RESP) && mem_rvalid;
  assign timeout    = busy && expired && !completion;
  assign passthru   = idle && ex_valid && write_reg && !load_en && !store_en;

  assign stall = start || (busy && !completion && !timeout);

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req && !is_load_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  lsu_timeout_cnt #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .en      (busy),
    .expired (expired)
  );

  // Next-state selection for the IDLE/REQ/RESP transaction FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ: begin
        if (timeout)      state_d = ST_IDLE;
        else if (mem_gnt) state_d = ST_RESP;
      end
      ST_RESP: if (completion || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and transaction latches captured on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q    <= ex_res;
        wdata_q   <= ex_store_data;
        rd_q      <= ex_rd;
        is_load_q <= load_en;
      end
    end
  end

  // Registered writeback and single-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_en        <= (completion && is_load_q) || passthru;
      misalign_err <= accept && !aligned;
      bus_err      <= timeout;
      if (completion && is_load_q) begin
        wb_rd   <= rd_q;
        wb_data <= mem_rdata;
      end else if (passthru) begin
        wb_rd   <= ex_rd;
        wb_data <= ex_res;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, load_en, store_en, write_reg;
  logic [31:0] ex_res, ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err, bus_err;

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .load_en(load_en),
    .store_en(store_en), .write_reg(write_reg), .ex_res(ex_res),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind = {wb_en, misalign_err, bus_err}
  typedef struct {
    int         due;
    logic [2:0] kind;
    logic [4:0] rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_evt(input logic [2:0] kind, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.due = cyc + 1; e.kind = kind; e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard at its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_kind", {29'd0, wb_en, misalign_err, bus_err}, {29'd0, e.kind});
        if (e.kind[2]) begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("wb_data", wb_data, e.data);
        end
      end else if (wb_en || misalign_err || bus_err) begin
        chk("spurious_event", {29'd0, wb_en, misalign_err, bus_err}, 32'd0);
      end
    end
  end

  task automatic idle_cycle(input bit stray);
    ex_valid = 0; load_en = 0; store_en = 0; write_reg = 0;
    mem_gnt = 0; mem_rvalid = stray; mem_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input bit wr);
    ex_valid = 1; load_en = 0; store_en = 0; write_reg = wr;
    ex_res = res; ex_rd = rd; ex_store_data = $urandom;
    mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    chk("alu_req", {31'd0, mem_req}, 32'd0);
    if (wr) push_evt(3'b100, rd, res);
    @(posedge clk); #1;
  endtask

  // One load/store; gd = REQ cycles before gnt, rl = RESP cycles before rvalid.
  task automatic mem_op(input bit is_ld, input bit both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int gd, input int rl);
    int  n = 0;
    int  wait_cnt = 0;
    bit  granted = 0;
    bit  done = 0;
    bit  fin, tmo;
    ex_valid = 1; load_en = is_ld; store_en = !is_ld || both; write_reg = is_ld;
    ex_res = addr; ex_store_data = wdata; ex_rd = rd;
    mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    chk("accept_req", {31'd0, mem_req}, 32'd0);
    if (addr[1:0] != 2'b00) begin
      chk("misalign_stall", {31'd0, stall}, 32'd0);
      push_evt(3'b010, 5'd0, 32'd0);
      @(posedge clk); #1;
      return;
    end
    chk("accept_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    while (!done) begin
      n++;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      fin = 0; tmo = 0;
      if (!granted) mem_gnt = (wait_cnt == gd);
      else begin
        mem_rvalid = (wait_cnt == rl);
        fin = mem_rvalid;
        if (fin) mem_rdata = rdata;
      end
      if (!fin && n == TIMEOUT) tmo = 1;
      @(negedge clk);
      chk("mem_req", {31'd0, mem_req}, {31'd0, !granted});
      if (!granted) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, !is_ld});
        chk("mem_addr", mem_addr, addr);
        if (!is_ld) chk("mem_wdata", mem_wdata, wdata);
      end
      chk("busy_stall", {31'd0, stall}, {31'd0, !(fin || tmo)});
      if (fin) begin
        if (is_ld) push_evt(3'b100, rd, rdata);
        else mem_model[addr] = wdata;
        done = 1;
      end else if (tmo) begin
        push_evt(3'b001, 5'd0, 32'd0);
        done = 1;
      end
      if (!granted && mem_gnt) begin granted = 1; wait_cnt = 0; end
      else wait_cnt++;
      @(posedge clk); #1;
    end
    mem_gnt = 0; mem_rvalid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0; ex_valid = 0; load_en = 0; store_en = 0; write_reg = 0;
    ex_res = 0; ex_store_data = 0; ex_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    idle_cycle(0);

    // Load with gnt after one REQ cycle and one empty RESP cycle.
    mem_op(1, 0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 1, 1);
    // Store granted immediately, acked next cycle.
    mem_op(0, 0, 32'h40, 32'h12345678, 5'd9, 32'h0, 0, 0);
    idle_cycle(0);
    // Misaligned load.
    mem_op(1, 0, 32'h102, 32'h0, 5'd4, 32'h0, 0, 0);
    // Load with load_en and store_en both set behaves as a load.
    mem_op(1, 1, 32'h80, 32'hFFFF0000, 5'd6, 32'hCAFEF00D, 0, 2);
    // Timeout: granted, never answered; stray rvalid three cycles later.
    mem_op(1, 0, 32'h180, 32'h0, 5'd8, 32'h0, 0, 100);
    idle_cycle(0);
    idle_cycle(0);
    idle_cycle(1);
    // Timeout while still waiting for gnt.
    mem_op(0, 0, 32'h184, 32'h1, 5'd1, 32'h0, 100, 0);
    // Pass-through then back-to-back load; x0 pass-through still writes back.
    alu_op(32'h7, 5'd3, 1);
    mem_op(1, 0, 32'h104, 32'h0, 5'd12, 32'h0BADF00D, 0, 0);
    alu_op(32'h55, 5'd0, 1);
    alu_op(32'h66, 5'd2, 0);

    // Reset while waiting in RESP.
    ex_valid = 1; load_en = 1; store_en = 0; write_reg = 1;
    ex_res = 32'h300; ex_rd = 5'd7;
    @(posedge clk); #1;
    ex_valid = 0; load_en = 0; write_reg = 0; mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    @(negedge clk);
    chk("resp_stall", {31'd0, stall}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    chk("midrst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    idle_cycle(1);
    idle_cycle(0);

    // Randomised mix against the reference model.
    for (int i = 0; i < 160; i++) begin
      int k, gd, rl;
      logic [31:0] a, d;
      logic [4:0] rd;
      k  = $urandom_range(0, 9);
      gd = ($urandom_range(0, 11) == 0) ? 18 : $urandom_range(0, 3);
      rl = ($urandom_range(0, 11) == 0) ? 20 : $urandom_range(0, 4);
      a  = 32'h200 + ($urandom_range(0, 15) * 4);
      d  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case (k)
        0, 1: alu_op(d, rd, 1);
        2:    alu_op(d, rd, 0);
        3:    idle_cycle(1'($urandom_range(0, 1)));
        4:    mem_op(1'($urandom_range(0, 1)), 0, a | 32'($urandom_range(1, 3)), d, rd, 32'h0, 0, 0);
        5, 6, 7: mem_op(1, 1'($urandom_range(0, 1)), a, d, rd,
                        mem_model.exists(a) ? mem_model[a] : $urandom, gd, rl);
        default: mem_op(0, 0, a, d, rd, 32'h0, gd, rl);
      endcase
    end

    idle_cycle(0);
    idle_cycle(0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
